// File: rtl/act_writeback.sv
// Activation and writeback stage: applies pass/ReLU/leaky-shift per int8 lane, buffers rows
// in a show-ahead FIFO toward the output writer and pulses done once a full tile has drained.
module act_writeback #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ROWS   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 act_mode,
  input  logic [2:0]                 leaky_shift,
  input  logic [LANES*DATA_W-1:0]    bias_output,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [LANES*DATA_W-1:0]    out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(ROWS+1)-1:0]  row_count,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned RowW = LANES * DATA_W;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned RcW  = $clog2(ROWS + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [2:0]      shift_q, shift_d;
  logic [RcW-1:0]  row_q, row_d;

  logic [RowW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;

  logic            full;
  logic            push;
  logic            pop;
  logic [RowW-1:0] act_row;

  assign full      = (count_q == CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign in_ready  = (state_q == StRun) && !full;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_q[rd_ptr_q];
  assign row_count = row_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

  // Per-lane activation on the incoming row; only negatives are altered.
  always_comb begin
    logic signed [DATA_W-1:0] lane;
    act_row = '0;
    lane    = '0;
    for (int i = 0; i < LANES; i++) begin
      lane = bias_output[i*DATA_W +: DATA_W];
      case (mode_q)
        2'd1:    act_row[i*DATA_W +: DATA_W] = lane[DATA_W-1] ? '0 : lane;
        2'd2:    act_row[i*DATA_W +: DATA_W] = lane[DATA_W-1] ? (lane >>> shift_q) : lane;
        default: act_row[i*DATA_W +: DATA_W] = lane;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    shift_d = shift_q;
    row_d   = row_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = act_mode;
          shift_d = leaky_shift;
          row_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (push) begin
          row_d = row_q + 1'b1;
          if ((row_q + 1'b1) == RcW'(ROWS)) begin
            state_d = StDrain;
          end
        end
      end
      // count_d already reflects a pop in this cycle, so the last pop exits directly.
      StDrain: begin
        if (count_d == '0) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= '0;
      shift_q <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      shift_q <= shift_d;
      row_q   <= row_d;
    end
  end

  // Storage is cleared on reset so out_data reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= act_row;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_act_writeback.sv
// Randomised scoreboard bench for act_writeback with directed activation vectors,
// backpressure, full-tile completion and mid-tile reset scenarios.
module tb_act_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  act_mode = '0;
  logic [2:0]  leaky_shift = '0;
  logic [63:0] bias_output = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  row_count;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_pop_cyc = -10;
  int ready_mode = 3;
  logic [1:0] cur_mode = '0;
  int cur_shift = 0;
  logic [63:0] exp_q[$];

  act_writeback #(.LANES(8), .DATA_W(8), .DEPTH(4), .ROWS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .act_mode(act_mode), .leaky_shift(leaky_shift),
    .bias_output(bias_output), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .row_count(row_count), .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference activation: ReLU clamps negatives, leaky divides negatives by 2^s rounding down.
  function automatic logic [63:0] model(input logic [63:0] v, input logic [1:0] m, input int s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      int x;
      int y;
      int d;
      x = $signed(v[i*8 +: 8]);
      y = x;
      if (m == 2'd1 && x < 0) y = 0;
      if (m == 2'd2 && x < 0) begin
        d = 1 << s;
        y = (x - (d - 1)) / d;
      end
      r[i*8 +: 8] = y[7:0];
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: handshakes are observed mid-cycle, ahead of the edge that performs them.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("out_valid_vs_model", 64'(out_valid), 64'(exp_q.size() != 0));
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) chk("out_data", out_data, exp_q.pop_front());
        last_pop_cyc = cyc;
      end
      if (in_valid && in_ready) exp_q.push_back(model(bias_output, cur_mode, cur_shift));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [1:0] m, input logic [2:0] s);
    act_mode = m;
    leaky_shift = s;
    cur_mode = m;
    cur_shift = int'(s);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("row_count_cleared", 64'(row_count), 64'd0);
  endtask

  task automatic feed_row(input logic [63:0] d);
    bit ok;
    ok = 0;
    bias_output = d;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("accept_within_bound", 64'(ok), 64'd1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("done_after_last_pop", 64'(cyc), 64'(last_pop_cyc + 1));
    chk("fifo_empty_at_done", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
    chk("row_count_held", 64'(row_count), 64'd8);
    chk("in_ready_idle", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_tile(input logic [1:0] m, input logic [2:0] s, input int rm,
                          input logic [63:0] first, input logic [63:0] first_exp);
    logic [63:0] d;
    ready_mode = rm;
    do_start(m, s);
    for (int r = 0; r < 8; r++) begin
      d = (r == 0) ? first : {$urandom, $urandom};
      feed_row(d);
      chk("row_count_step", 64'(row_count), 64'(r + 1));
      if (r == 0) begin
        chk("first_out_valid", 64'(out_valid), 64'd1);
        chk("first_out_data", out_data, first_exp);
      end
      if (r == 3) begin
        // A second start mid-tile must not re-latch the mode.
        act_mode = ~m;
        leaky_shift = ~s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    chk("in_ready_low_in_drain", 64'(in_ready), 64'd0);
    wait_done();
  endtask

  initial begin
    logic [63:0] vec;
    int extra;
    bit done_seen;
    vec = 64'h80FF7F01F01000C8;
    #23;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_busy_done", {busy, done, row_count}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    bias_output = vec;
    repeat (3) @(negedge clk);
    chk("idle_no_accept", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    run_tile(2'd1, 3'd0, 1, vec, 64'h00007F0100100000);
    run_tile(2'd2, 3'd2, 1, vec, 64'hE0FF7F01FC1000F2);
    run_tile(2'd0, 3'd5, 2, vec, vec);
    run_tile(2'd2, 3'd7, 2, vec, 64'hFFFF7F01FF1000FF);
    run_tile(2'd3, 3'd1, 0, vec, vec);

    // Backpressure: consumer stalled, exactly DEPTH rows fit.
    ready_mode = 3;
    do_start(2'd2, 3'(1));
    for (int r = 0; r < 4; r++) feed_row({$urandom, $urandom});
    extra = 0;
    bias_output = {$urandom, $urandom};
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (in_ready) extra++;
    end
    chk("backpressure_extra_accepts", 64'(extra), 64'd0);
    chk("backpressure_row_count", 64'(row_count), 64'd4);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ready_mode = 0;
    for (int r = 0; r < 4; r++) feed_row({$urandom, $urandom});
    wait_done();

    // Mid-tile asynchronous reset.
    ready_mode = 2;
    do_start(2'd1, 3'd0);
    for (int r = 0; r < 3; r++) feed_row({$urandom, $urandom});
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_out_data", out_data, 64'd0);
    chk("midreset_ctrl", {in_ready, busy, done, row_count}, 64'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    #2;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    chk("midreset_no_done", 64'(done_seen), 64'd0);
    @(posedge clk);
    #1;
    run_tile(2'd2, 3'd3, 1, vec, model(vec, 2'd2, 3));

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
